// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and op-decode helpers for the divider issue controller
package div_pkg;

  typedef enum logic [1:0] {
    DIV_W  = 2'd0,
    MOD_W  = 2'd1,
    DIV_WU = 2'd2,
    MOD_WU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  function automatic logic is_signed(div_op_t op);
    return (op == DIV_W) || (op == MOD_W);
  endfunction

  function automatic logic is_mod(div_op_t op);
    return (op == MOD_W) || (op == MOD_WU);
  endfunction

  // 32-bit two's-complement abs; 0x80000000 maps to itself
  function automatic logic [31:0] abs32(logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - selects quotient or remainder and restores the sign for signed ops
module div_sign_fix
  import div_pkg::*;
(
  input  logic [1:0]  op,
  input  logic        q_sign,
  input  logic        r_sign,
  input  logic [31:0] quo_raw,
  input  logic [31:0] rem_raw,
  output logic [31:0] result
);

  div_op_t     op_e;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op_e    = div_op_t'(op);
  assign quo_fix = (is_signed(op_e) && q_sign) ? (~quo_raw + 32'd1) : quo_raw;
  assign rem_fix = (is_signed(op_e) && r_sign) ? (~rem_raw + 32'd1) : rem_raw;
  assign result  = is_mod(op_e) ? rem_fix : quo_fix;

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issues one division to div_gen_0 and returns the sign-corrected result
// Optional zero-divisor shortcut: DIV_ZERO_BYPASS_EN.
module div_issue_ctrl
  import div_pkg::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        div_divisor_tvalid,
  output logic        div_dividend_tvalid,
  output logic [31:0] div_divisor_tdata,
  output logic [31:0] div_dividend_tdata,
  input  logic        div_dout_tvalid,
  input  logic [63:0] div_dout_tdata
);

  div_state_t  state_q, state_d;
  div_op_t     op_q, op_d;
  logic        q_sign_q, q_sign_d;
  logic        r_sign_q, r_sign_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] result_q, result_d;

  div_op_t     req_op_e;
  logic        req_accept;
  logic [31:0] fixed_result;

  assign req_op_e   = div_op_t'(req_op);
  assign req_ready  = (state_q == IDLE) && !flush;
  assign req_accept = req_valid && req_ready;

  div_sign_fix u_sign_fix (
    .op      (op_q),
    .q_sign  (q_sign_q),
    .r_sign  (r_sign_q),
    .quo_raw (div_dout_tdata[63:32]),
    .rem_raw (div_dout_tdata[31:0]),
    .result  (fixed_result)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    q_sign_d   = q_sign_q;
    r_sign_d   = r_sign_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (req_accept) begin
          op_d       = req_op_e;
          q_sign_d   = req_src1[31] ^ req_src2[31];
          r_sign_d   = req_src1[31];
          dividend_d = is_signed(req_op_e) ? abs32(req_src1) : req_src1;
          divisor_d  = is_signed(req_op_e) ? abs32(req_src2) : req_src2;
          state_d    = SEND;
`ifdef DIV_ZERO_BYPASS_EN
          if (req_src2 == 32'd0) begin
            result_d = is_mod(req_op_e) ? req_src1 : 32'hFFFF_FFFF;
            state_d  = DONE;
          end
`endif
        end
      end
      // The divider has already sampled the operands, so a flush here must drain.
      SEND: state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush) begin
          state_d = div_dout_tvalid ? IDLE : DRAIN;
        end else if (div_dout_tvalid) begin
          result_d = fixed_result;
          state_d  = DONE;
        end
      end
      DRAIN: begin
        if (div_dout_tvalid) state_d = IDLE;
      end
      DONE: begin
        if (resp_ready || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      op_q       <= DIV_W;
      q_sign_q   <= 1'b0;
      r_sign_q   <= 1'b0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      q_sign_q   <= q_sign_d;
      r_sign_q   <= r_sign_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
    end
  end

  assign resp_valid          = (state_q == DONE);
  assign resp_result         = result_q;
  assign div_divisor_tvalid  = (state_q == SEND);
  assign div_dividend_tvalid = (state_q == SEND);
  assign div_divisor_tdata   = divisor_q;
  assign div_dividend_tdata  = dividend_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - table-driven scoreboard bench for div_issue_ctrl with a 31-cycle divider model
module tb_div_issue_ctrl;

  logic        aclk;
  logic        areset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        div_divisor_tvalid;
  logic        div_dividend_tvalid;
  logic [31:0] div_divisor_tdata;
  logic [31:0] div_dividend_tdata;
  logic        div_dout_tvalid;
  logic [63:0] div_dout_tdata;

  div_issue_ctrl dut (
    .aclk                (aclk),
    .areset              (areset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_op              (req_op),
    .req_src1            (req_src1),
    .req_src2            (req_src2),
    .flush               (flush),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_result         (resp_result),
    .div_divisor_tvalid  (div_divisor_tvalid),
    .div_dividend_tvalid (div_dividend_tvalid),
    .div_divisor_tdata   (div_divisor_tdata),
    .div_dividend_tdata  (div_dividend_tdata),
    .div_dout_tvalid     (div_dout_tvalid),
    .div_dout_tdata      (div_dout_tdata)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] exp_q[$];
  vec_t        tbl[10];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Divider model: samples at the SEND edge, pulses dout for one cycle 31 edges later
  logic [31:0] m_a, m_b;
  int          m_cnt;
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_cnt           <= 0;
      m_a             <= 32'd0;
      m_b             <= 32'd0;
      div_dout_tvalid <= 1'b0;
      div_dout_tdata  <= 64'd0;
    end else begin
      div_dout_tvalid <= 1'b0;
      if (div_divisor_tvalid && div_dividend_tvalid) begin
        m_a   <= div_dividend_tdata;
        m_b   <= div_divisor_tdata;
        m_cnt <= 31;
      end else if (m_cnt == 1) begin
        div_dout_tvalid <= 1'b1;
        div_dout_tdata  <= (m_b == 32'd0) ? {32'hFFFF_FFFF, m_a} : {m_a / m_b, m_a % m_b};
        m_cnt           <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

`ifdef DIV_ZERO_BYPASS_EN
  int tv_cnt = 0;
  always @(posedge aclk) if (div_divisor_tvalid || div_dividend_tvalid) tv_cnt <= tv_cnt + 1;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Returns at the negedge after the accepting edge (the SEND cycle, or DONE when bypassed).
  task automatic issue(input vec_t v, input bit push, input bit byp);
    int n;
    @(negedge aclk);
    req_valid = 1'b1;
    req_op    = v.op;
    req_src1  = v.a;
    req_src2  = v.b;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge aclk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    if (push) exp_q.push_back(v.exp);
    if (byp) begin
      check("bypass_resp_valid", 32'(resp_valid), 32'd1);
      check("bypass_no_tvalid", 32'({div_divisor_tvalid, div_dividend_tvalid}), 32'd0);
    end else begin
      check("send_tvalid", 32'({div_divisor_tvalid, div_dividend_tvalid}), 32'd3);
      check("send_dividend", div_dividend_tdata, v.mag_a);
      check("send_divisor", div_divisor_tdata, v.mag_b);
    end
  endtask

  task automatic collect(input string name, input int exp_lat);
    int          n;
    logic [31:0] e;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check({name, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check({name, "_unexpected_resp"}, 32'(exp_q.size()), 32'd1);
      e = 32'd0;
    end else begin
      e = exp_q.pop_front();
      check({name, "_result"}, resp_result, e);
    end
    resp_ready = 1'b1;
    @(negedge aclk);
    resp_ready = 1'b0;
    check({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int          bad;
    int          n;
    logic [31:0] r0;
    vec_t        v;

    tbl[0] = '{2'd0, 32'd100,        32'hFFFF_FFF9, 32'd100,        32'd7,         32'hFFFF_FFF2};
    tbl[1] = '{2'd1, 32'd100,        32'hFFFF_FFF9, 32'd100,        32'd7,         32'd2};
    tbl[2] = '{2'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF};
    tbl[3] = '{2'd3, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF,  32'd2,         32'd1};
    tbl[4] = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  32'd1,         32'h8000_0000};
    tbl[5] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  32'd1,         32'd0};
    tbl[6] = '{2'd1, 32'hFFFF_FFF7,  32'd4,         32'd9,          32'd4,         32'hFFFF_FFFF};
    tbl[7] = '{2'd0, 32'hFFFF_FFF7,  32'd4,         32'd9,          32'd4,         32'hFFFF_FFFE};
    tbl[8] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    tbl[9] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};

    areset     = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_src1   = 32'd0;
    req_src2   = 32'd0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_tvalid", 32'({div_divisor_tvalid, div_dividend_tvalid}), 32'd0);
    check("rst_dividend", div_dividend_tdata, 32'd0);
    check("rst_divisor", div_divisor_tdata, 32'd0);
    check("rst_result", resp_result, 32'd0);

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i], 1'b1, 1'b0);
      collect($sformatf("vec%0d", i), 33);
    end

    // Flush five cycles after acceptance while a new request waits
    issue(tbl[0], 1'b0, 1'b0);
    repeat (4) @(negedge aclk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_src1  = 32'hFFFF_FFF7;
    req_src2  = 32'd4;
    @(negedge aclk);
    flush = 1'b0;
    bad = 0;
    n = 0;
    while (cyc < acc_cyc + 33 && n < 60) begin
      if (req_ready || resp_valid) bad++;
      @(negedge aclk);
      n++;
    end
    check("flush_quiet", 32'(bad), 32'd0);
    check("flush_ready_after_drain", 32'(req_ready), 32'd1);
    check("flush_no_resp", 32'(resp_valid), 32'd0);
    @(negedge aclk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFF);
    check("flush_next_dividend", div_dividend_tdata, 32'd9);
    check("flush_next_divisor", div_divisor_tdata, 32'd4);
    collect("flush_next", 33);

    // Response back-pressure with another request pending
    issue(tbl[2], 1'b1, 1'b0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("bp_resp_valid", 32'(resp_valid), 32'd1);
    r0 = resp_result;
    check("bp_result", r0, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
    req_valid = 1'b1;
    req_op    = 2'd3;
    req_src1  = 32'd7;
    req_src2  = 32'd3;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (resp_result !== r0 || !resp_valid || req_ready) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    check("bp_no_send", 32'({div_divisor_tvalid, div_dividend_tvalid}), 32'd0);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge aclk);
    resp_ready = 1'b0;
    check("bp_ready_next", 32'(req_ready), 32'd1);
    check("bp_resp_dropped", 32'(resp_valid), 32'd0);

    // Reset in the middle of a division
    issue(tbl[7], 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    areset = 1'b1;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    issue(tbl[6], 1'b1, 1'b0);
    collect("after_rst", 33);

`ifdef DIV_ZERO_BYPASS_EN
    n = tv_cnt;
    v = '{2'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    issue(v, 1'b1, 1'b1);
    collect("byp_div", 0);
    v = '{2'd1, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5};
    issue(v, 1'b1, 1'b1);
    collect("byp_mod", 0);
    repeat (40) @(negedge aclk);
    check("byp_tvalid_count", 32'(tv_cnt - n), 32'd0);
`else
    v = tbl[3];
    issue(v, 1'b1, 1'b0);
    collect("final", 33);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
